// File: rtl/alu_multiciclo.sv
// rtl/alu_multiciclo.sv - multicycle MIPS ALU with start/busy/done handshake
//
// Purpose: logic, add/sub and slt finish in one cycle; unsigned multiply
// (shift-add) and unsigned divide (restoring) take ANCHO iteration cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   inicio     start request, honoured only while idle
//   control    4-bit operation code from the ALU-control decoder
//   a, b       operands (rs, rt/immediate)
//   resultado  registered result, held until the next completion
//   cero       registered flag, resultado == 0
//   listo      one-cycle completion pulse
//   ocupado    high from the cycle after capture through the listo cycle

module alu_multiciclo #(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [3:0]       control,
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  output logic [ANCHO-1:0] resultado,
  output logic             cero,
  output logic             listo,
  output logic             ocupado
);

  localparam int CW = (ANCHO > 1) ? $clog2(ANCHO) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIN  = 2'd2
  } estado_t;

  estado_t          r_estado;
  logic             r_es_div;
  logic [CW-1:0]    r_cnt;
  // Shared iteration registers:
  //   mul: r_x = partial product, r_y = multiplicand (shifts left),
  //        r_z = multiplier (shifts right)
  //   div: r_x = partial remainder, r_y = divisor,
  //        r_z = dividend shifting out at the top, quotient bits in at the bottom
  logic [ANCHO-1:0] r_x;
  logic [ANCHO-1:0] r_y;
  logic [ANCHO-1:0] r_z;
  logic [ANCHO-1:0] r_res;
  logic             r_cero;
  logic             r_listo;
  logic             r_ocupado;

  logic [ANCHO-1:0] w_simple;
  logic [ANCHO-1:0] w_mul_acc;
  logic [ANCHO:0]   w_rem_sh;
  logic [ANCHO:0]   w_diff;
  logic             w_q_bit;
  logic [ANCHO-1:0] w_rem_nxt;
  logic [ANCHO-1:0] w_quo_nxt;
  logic [ANCHO-1:0] w_fin;
  logic             w_iterativa;

  assign w_iterativa = (control == OP_MUL) || (control == OP_DIV);

  // Single-cycle datapath, evaluated from the operands present at capture.
  always_comb begin
    w_simple = '0;
    case (control)
      OP_ADD:  w_simple = a + b;
      OP_SUB:  w_simple = a - b;
      OP_AND:  w_simple = a & b;
      OP_OR:   w_simple = a | b;
      OP_XOR:  w_simple = a ^ b;
      OP_NOR:  w_simple = ~(a | b);
      OP_SLT:  w_simple = {{(ANCHO-1){1'b0}}, ($signed(a) < $signed(b))};
      default: w_simple = '0;
    endcase
  end

  // One shift-add step.
  assign w_mul_acc = r_z[0] ? (r_x + r_y) : r_x;

  // One restoring-division step. A zero divisor never produces a borrow,
  // so every quotient bit comes out 1 and the quotient is all ones.
  assign w_rem_sh  = {r_x, r_z[ANCHO-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_y};
  assign w_q_bit   = ~w_diff[ANCHO];
  assign w_rem_nxt = w_q_bit ? w_diff[ANCHO-1:0] : w_rem_sh[ANCHO-1:0];
  assign w_quo_nxt = {r_z[ANCHO-2:0], w_q_bit};

  assign w_fin = r_es_div ? w_quo_nxt : w_mul_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado  <= S_IDLE;
      r_es_div  <= 1'b0;
      r_cnt     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_res     <= '0;
      r_cero    <= 1'b1;
      r_listo   <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      case (r_estado)
        S_IDLE: begin
          if (inicio) begin
            r_ocupado <= 1'b1;
            if (w_iterativa) begin
              r_es_div <= (control == OP_DIV);
              r_cnt    <= CW'(ANCHO - 1);
              r_x      <= '0;
              if (control == OP_DIV) begin
                r_y <= b;
                r_z <= a;
              end else begin
                r_y <= a;
                r_z <= b;
              end
              r_estado <= S_ITER;
            end else begin
              r_res    <= w_simple;
              r_cero   <= (w_simple == '0);
              r_listo  <= 1'b1;
              r_estado <= S_FIN;
            end
          end
        end

        S_ITER: begin
          if (r_es_div) begin
            r_x <= w_rem_nxt;
            r_z <= w_quo_nxt;
          end else begin
            r_x <= w_mul_acc;
            r_y <= r_y << 1;
            r_z <= r_z >> 1;
          end
          // The last step's value goes straight to the result register.
          if (r_cnt == '0) begin
            r_res    <= w_fin;
            r_cero   <= (w_fin == '0);
            r_listo  <= 1'b1;
            r_estado <= S_FIN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_FIN: begin
          r_listo   <= 1'b0;
          r_ocupado <= 1'b0;
          r_estado  <= S_IDLE;
        end

        default: begin
          r_listo   <= 1'b0;
          r_ocupado <= 1'b0;
          r_estado  <= S_IDLE;
        end
      endcase
    end
  end

  assign resultado = r_res;
  assign cero      = r_cero;
  assign listo     = r_listo;
  assign ocupado   = r_ocupado;

endmodule

// File: tb/tb_alu_multiciclo.sv
// tb/tb_alu_multiciclo.sv - self-checking bench for alu_multiciclo
module tb_alu_multiciclo;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic         clk = 1'b0;
  logic         rst;
  logic         inicio;
  logic [3:0]   control;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] resultado;
  logic         cero;
  logic         listo;
  logic         ocupado;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  alu_multiciclo #(.ANCHO(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .inicio    (inicio),
    .control   (control),
    .a         (a),
    .b         (b),
    .resultado (resultado),
    .cero      (cero),
    .listo     (listo),
    .ocupado   (ocupado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of an opcode, straight from the opcode table.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_NOR:  return ~(x | y);
      OP_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      OP_MUL:  return x * y;
      OP_DIV:  return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    return (op == OP_MUL || op == OP_DIV) ? LAT : 1;
  endfunction

  // Behavioural model: m_left = cycles still to go in the current operation,
  // counting the listo cycle; zero means idle and able to accept inicio.
  int          m_left = 0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_res  <= '0;
    end else if (m_left == 0) begin
      if (inicio) begin
        m_left <= ref_lat(control);
        if (ref_lat(control) == 1) m_res <= ref_alu(control, a, b);
        else m_pend <= ref_alu(control, a, b);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) m_res <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_resultado", resultado, m_res);
      chk_bit("cyc_cero", cero, (m_res == '0));
      chk_bit("cyc_listo", listo, (m_left == 1));
      chk_bit("cyc_ocupado", ocupado, (m_left > 0));
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] exp, input int exp_lat, input string nm);
    int lat;
    int occ;
    logic [31:0] res;
    chk({"model_", nm}, ref_alu(op, aa, bb), exp);
    @(negedge clk);
    control = op; a = aa; b = bb; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    lat = 1;
    occ = 0;
    while (!listo && lat < 100) begin
      if (ocupado) occ++;
      @(negedge clk);
      lat++;
    end
    if (ocupado) occ++;
    res = resultado;
    chk({nm, "_result"}, res, exp);
    chk_bit({nm, "_cero"}, cero, (exp == 32'd0));
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_busy_cycles"}, occ, exp_lat);
    a = $urandom; b = $urandom; control = 4'($urandom);
  endtask

  initial begin
    int cyc;
    int pulses;
    int first;
    logic [31:0] res;
    logic [3:0] ops [12];
    ops = '{OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLT, OP_NOR, OP_MUL, OP_DIV,
            4'b0011, 4'b1111, 4'b0100};

    // Reset held two cycles with inicio high: nothing may start.
    rst = 1'b1; inicio = 1'b1; control = OP_ADD; a = 32'd3; b = 32'd4;
    chk_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_resultado", resultado, 32'd0);
      chk_bit("rst_cero", cero, 1'b1);
      chk_bit("rst_listo", listo, 1'b0);
      chk_bit("rst_ocupado", ocupado, 1'b0);
    end
    rst = 1'b0; inicio = 1'b0;
    @(negedge clk);

    run_op(OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, "add_wrap");
    run_op(OP_SLT, 32'hFFFF_FFFE, 32'd3, 32'd1, 1, "slt_neg");
    run_op(OP_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1, "nor_zero");
    run_op(OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, "sub_wrap");
    run_op(4'b1111, 32'd9, 32'd9, 32'd0, 1, "undef_op");
    run_op(OP_MUL, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, LAT, "mul");
    run_op(OP_DIV, 32'd100, 32'd7, 32'd14, LAT, "div");
    run_op(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT, "div_by_zero");

    // Interference: add request and operand changes during a multiply.
    @(negedge clk);
    control = OP_MUL; a = 32'h0001_0001; b = 32'h0001_0001; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    pulses = 0; first = 0; res = '0;
    for (cyc = 1; cyc <= 45; cyc++) begin
      if (listo) begin
        pulses++;
        if (first == 0) begin
          first = cyc;
          res = resultado;
        end
      end
      if (cyc == 10) begin
        control = OP_ADD; a = 32'd5; b = 32'd6; inicio = 1'b1;
      end else if (cyc == 11) begin
        inicio = 1'b0;
      end else if (cyc == 12) begin
        a = $urandom; b = $urandom;
      end
      @(negedge clk);
    end
    chk("intf_listo_pulses", pulses, 1);
    chk("intf_latency", first, LAT);
    chk("intf_result", res, 32'h0002_0001);

    // Abort a divide on its 15th cycle.
    control = OP_DIV; a = 32'd1000; b = 32'd3; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    for (cyc = 1; cyc < 15; cyc++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_resultado", resultado, 32'd0);
    chk_bit("abort_cero", cero, 1'b1);
    chk_bit("abort_listo", listo, 1'b0);
    chk_bit("abort_ocupado", ocupado, 1'b0);
    pulses = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (listo) pulses++;
      @(negedge clk);
    end
    chk("abort_no_listo", pulses, 0);
    run_op(OP_ADD, 32'd2, 32'd3, 32'd5, 1, "add_after_abort");

    // Randomized traffic; the per-cycle compare against the model does the checking.
    for (cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 299) == 0);
      inicio  = ($urandom_range(0, 3) != 0);
      control = ops[$urandom_range(0, 11)];
      a       = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 255);
        2:       b = a;
        default: b = $urandom;
      endcase
    end
    rst = 1'b0; inicio = 1'b0;
    repeat (LAT + 3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
